// File: rtl/serial_in.sv
// serial_in: tick-timed serial word receiver, LSB first, with idle/recv/done FSM.
// Define SERIAL_IN_MAJORITY_EN for a 2-of-3 vote around mid-bit instead of a single sample.
module serial_in #(
  parameter int DATA_BIT     = 16,
  parameter int TICK_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_tick,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_continuous,
  input  logic                i_serial,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_done_tick,
  output logic                o_busy
);

  localparam int TW = $clog2(TICK_PER_BIT);
  localparam int BW = $clog2(DATA_BIT);
  localparam logic [TW-1:0] TICK_MID  = TW'(TICK_PER_BIT / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BIT - 1);

  if (DATA_BIT < 2 || DATA_BIT > 64) begin : g_bad_data_bit
    $error("serial_in: DATA_BIT must be in 2..64");
  end
  if (TICK_PER_BIT < 2) begin : g_bad_tick_per_bit
    $error("serial_in: TICK_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BIT-1:0]   shift_q, shift_d;
  logic [DATA_BIT-1:0]   data_d;
  logic                  sample_en;
  logic                  sample_bit;

`ifdef SERIAL_IN_MAJORITY_EN
  localparam logic [TW-1:0] TICK_VOTE0 = TW'(TICK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_VOTE2 = TW'(TICK_PER_BIT / 2 + 1);

  if (TICK_PER_BIT < 4) begin : g_bad_vote_ticks
    $error("serial_in: majority voting needs TICK_PER_BIT >= 4");
  end

  logic [1:0] vote_q, vote_d;

  // The first two votes are held; the third is the live input at H+1.
  always_comb begin
    vote_d = vote_q;
    if (state_q == S_RECV && i_tick) begin
      if (tick_q == TICK_VOTE0) vote_d[0] = i_serial;
      if (tick_q == TICK_MID)   vote_d[1] = i_serial;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vote_q <= '0;
    else     vote_q <= vote_d;
  end

  assign sample_en  = (tick_q == TICK_VOTE2);
  assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & i_serial) | (vote_q[1] & i_serial);
`else
  assign sample_en  = (tick_q == TICK_MID);
  assign sample_bit = i_serial;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = o_data;
    o_done_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_d  = '0;
        bit_d   = '0;
        shift_d = '0;
        if (i_start) state_d = S_RECV;
      end
      S_RECV: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_tick) begin
          if (sample_en) shift_d = {sample_bit, shift_q[DATA_BIT-1:1]};
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            // The sample point may fall on the last tick, so load the updated shift value.
            if (bit_q == BIT_LAST) begin
              data_d  = shift_d;
              state_d = S_DONE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        o_done_tick = 1'b1;
        if (i_continuous) begin
          state_d = S_RECV;
          tick_d  = '0;
          bit_d   = '0;
          shift_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      o_data  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      o_data  <= data_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: randomized loopback-style bench for serial_in; the reference model derives
// each received word from the transmitted word and the mid-bit sampling rule.
module tb_serial_in;

  localparam int DW  = 16;
  localparam int TPB = 16;
  localparam int H   = TPB / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_tick, i_start, i_stop, i_continuous, i_serial;
  logic [DW-1:0] o_data;
  logic          o_done_tick, o_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tx_words [4];
  logic [DW-1:0] rx_words [$];
  int            done_edges [$];
  int            busy_cnt;
  bit            timed_out;

  always #5 clk = ~clk;

  serial_in #(.DATA_BIT(DW), .TICK_PER_BIT(TPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_continuous(i_continuous),
    .i_serial    (i_serial),
    .o_data      (o_data),
    .o_done_tick (o_done_tick),
    .o_busy      (o_busy)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: a clean bit is read back unchanged; a flip confined to the mid-bit tick
  // corrupts a single sample but is outvoted by its neighbours under majority voting.
  function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] w, input bit glitch);
`ifdef SERIAL_IN_MAJORITY_EN
    return w;
`else
    return glitch ? ~w : w;
`endif
  endfunction

  // Transmits nw words (one clk gap between words in continuous mode), each bit lasting
  // TPB ticks, ticks arriving every tick_per clks. Edge numbers are counted from E0.
  task automatic drive_frames(input int nw, input int tick_per, input bit glitch,
                              input bit cont, input int stop_bit);
    int cyc, ticks, widx, b, k;
    bit gap, tick_now, bitv, stopping;
    int bound;
    bound = nw * (tick_per * DW * TPB + 8) + 16;
    rx_words.delete();
    done_edges.delete();
    busy_cnt  = 0;
    timed_out = 0;
    @(negedge clk);
    i_start = 1'b1; i_continuous = cont; i_tick = 1'b0; i_serial = 1'b0; i_stop = 1'b0;
    @(posedge clk);
    cyc = 0; ticks = 0; widx = 0; gap = 0;
    forever begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      if (cyc > bound) begin
        timed_out = 1;
        break;
      end
      tick_now = (cyc % tick_per) == 0;
      b = ticks / TPB;
      k = ticks % TPB;
      bitv = (b < DW) ? tx_words[widx][b] : 1'b0;
      if (glitch && tick_now && !gap && k == H) bitv = ~bitv;
      i_tick   = tick_now;
      i_serial = bitv;
      stopping = (stop_bit >= 0) && !gap && tick_now && (ticks == stop_bit * TPB);
      i_stop   = stopping;
      @(posedge clk);
      #1;
      if (o_busy) busy_cnt++;
      if (stopping) break;
      if (gap) gap = 0;
      else if (tick_now) ticks++;
      if (o_done_tick) begin
        rx_words.push_back(o_data);
        done_edges.push_back(cyc);
        widx++;
        ticks = 0;
        gap   = 1;
        if (widx == nw) break;
      end
    end
    i_stop       = 1'b0;
    i_continuous = 1'b0;
  endtask

  task automatic step;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_tick = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0; i_serial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0000", o_data); end
    checks++;
    if (o_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done_tick); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    tx_words[0] = 16'hA5C3;
    drive_frames(1, 1, 0, 0, -1);
    checks++;
    if (timed_out || rx_words.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d done pulses want 1", rx_words.size());
    end else begin
      checks++;
      if (rx_words[0] !== 16'hA5C3) begin errors++; $display("FAIL basic_data: got %h want a5c3", rx_words[0]); end
      checks++;
      if (done_edges[0] != DW * TPB) begin
        errors++; $display("FAIL basic_latency: done after edge E0+%0d want E0+%0d", done_edges[0], DW * TPB);
      end
    end
    step();
    checks++;
    if (o_done_tick !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_single_pulse: done=%b busy=%b want 0 0", o_done_tick, o_busy);
    end
  endtask

  task automatic test_slow_tick;
    tx_words[0] = 16'h0001;
    drive_frames(1, 4, 0, 0, -1);
    checks++;
    if (timed_out || rx_words.size() != 1) begin
      errors++; $display("FAIL slow_count: got %0d done pulses want 1", rx_words.size());
    end else begin
      checks++;
      if (rx_words[0] !== 16'h0001) begin errors++; $display("FAIL slow_data: got %h want 0001", rx_words[0]); end
      checks++;
      if (done_edges[0] != 4 * DW * TPB) begin
        errors++; $display("FAIL slow_latency: got E0+%0d want E0+%0d", done_edges[0], 4 * DW * TPB);
      end
    end
    checks++;
    if (busy_cnt < 4 * DW * TPB - 4 || busy_cnt > 4 * DW * TPB + 4) begin
      errors++; $display("FAIL slow_busy: busy for %0d clks want %0d +-4", busy_cnt, 4 * DW * TPB);
    end
    step();
  endtask

  task automatic test_abort;
    tx_words[0] = 16'h1234;
    drive_frames(1, 1, 0, 0, -1);
    checks++;
    if (o_data !== 16'h1234) begin errors++; $display("FAIL abort_preload: got %h want 1234", o_data); end
    step();
    tx_words[0] = 16'hFFFF;
    drive_frames(1, 1, 0, 0, 5);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    checks++;
    if (rx_words.size() != 0 || timed_out) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", rx_words.size());
    end
    step();
    checks++;
    if (o_data !== 16'h1234 || o_done_tick !== 1'b0) begin
      errors++; $display("FAIL abort_hold: data=%h done=%b want 1234 0", o_data, o_done_tick);
    end
  endtask

  task automatic test_continuous;
    tx_words[0] = 16'h00FF;
    tx_words[1] = 16'hFF00;
    drive_frames(2, 1, 0, 1, -1);
    checks++;
    if (timed_out || rx_words.size() != 2) begin
      errors++; $display("FAIL cont_count: got %0d done pulses want 2", rx_words.size());
    end else begin
      checks++;
      if (rx_words[0] !== 16'h00FF || rx_words[1] !== 16'hFF00) begin
        errors++; $display("FAIL cont_data: got %h %h want 00ff ff00", rx_words[0], rx_words[1]);
      end
      checks++;
      if (done_edges[1] - done_edges[0] != DW * TPB + 1) begin
        errors++; $display("FAIL cont_spacing: got %0d clks want %0d", done_edges[1] - done_edges[0], DW * TPB + 1);
      end
    end
    step();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL cont_idle: busy=%b want 0", o_busy); end
  endtask

  task automatic test_glitch;
    logic [DW-1:0] w;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 16'h0000 : 16'($urandom());
      tx_words[0] = w;
      drive_frames(1, 1, 1, 0, -1);
      checks++;
      if (timed_out || rx_words.size() != 1) begin
        errors++; $display("FAIL glitch_count[%0d]: got %0d done pulses want 1", i, rx_words.size());
      end else if (rx_words[0] !== expect_word(w, 1)) begin
        errors++; $display("FAIL glitch_data[%0d]: got %h want %h", i, rx_words[0], expect_word(w, 1));
      end
      step();
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    i_start = 1'b1; i_tick = 1'b1; i_serial = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (7 * TPB + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (o_data !== '0 || o_done_tick !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: data=%h done=%b busy=%b want 0000 0 0", o_data, o_done_tick, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tx_words[0] = 16'h5A5A;
    drive_frames(1, 1, 0, 0, -1);
    checks++;
    if (timed_out || rx_words.size() != 1) begin
      errors++; $display("FAIL reset_recover_count: got %0d done pulses want 1", rx_words.size());
    end else if (rx_words[0] !== 16'h5A5A) begin
      errors++; $display("FAIL reset_recover_data: got %h want 5a5a", rx_words[0]);
    end
    step();
  endtask

  task automatic test_random;
    logic [DW-1:0] w;
    int            tp;
    bit            g;
    for (int i = 0; i < 8; i++) begin
      w  = 16'($urandom());
      tp = $urandom_range(1, 3);
      g  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        i_serial = 1'($urandom());
        i_tick   = 1'($urandom());
      end
      tx_words[0] = w;
      drive_frames(1, tp, g, 0, -1);
      checks++;
      if (timed_out || rx_words.size() != 1) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d done pulses want 1", i, rx_words.size());
      end else begin
        checks++;
        if (rx_words[0] !== expect_word(w, g)) begin
          errors++; $display("FAIL rand_data[%0d]: got %h want %h (tick_per=%0d glitch=%0d)",
                             i, rx_words[0], expect_word(w, g), tp, g);
        end
        checks++;
        if (done_edges[0] != tp * DW * TPB) begin
          errors++; $display("FAIL rand_latency[%0d]: got E0+%0d want E0+%0d", i, done_edges[0], tp * DW * TPB);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_tick();
    test_abort();
    test_continuous();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_in.md
# serial_in

Serial receiver that reconstructs a DATA_BIT-wide word from a single-wire bit stream in which every bit lasts TICK_PER_BIT enable ticks, LSB first. It is the capture side of the frequency-selectable serial output path: it shares the same tick-based bit timing and start/stop/continuous semantics, so a loopback of the serializer output into this block returns the transmitted word. It sits on the input side of the serial link, feeding captured words to the register/control logic.

## Interface

Parameters:
- DATA_BIT, 16, word width and bits per frame; legal range 2..64.
- TICK_PER_BIT, 16, i_tick pulses per bit; must be ≥2, or ≥4 with majority voting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_tick  in  1  bit-timing enable, selects the effective rate; one-clk pulses.
- i_start  in  1  arm the receiver; sampled only in S_IDLE.
- i_stop  in  1  abort the frame in progress.
- i_continuous  in  1  when high at frame end, rearm immediately for the next frame.
- i_serial  in  1  serial input, already synchronous to clk.
- o_data  out  DATA_BIT  last completed word.
- o_done_tick  out  1  one-clk pulse, word complete.
- o_busy  out  1  high whenever state ≠ S_IDLE.

## Operation

- States: S_IDLE, S_RECV, S_DONE.
- Registers:
  - tick counter, $clog2(TICK_PER_BIT) bits.
  - bit counter, $clog2(DATA_BIT) bits.
  - shift register, DATA_BIT bits.
  - o_data.
- S_IDLE:
  - If i_start, go to S_RECV.
  - Clear the tick counter, the bit counter and the shift register.
- S_RECV, each clk with i_tick=1:
  - At tick count == TICK_PER_BIT/2 (integer division), sample i_serial.
  - The shift register shifts right, and the sample enters at the MSB.
  - At tick count == TICK_PER_BIT-1:
    - Clear the tick counter.
    - If bit count == DATA_BIT-1, load o_data from the shift register and go to S_DONE.
    - Otherwise increment the bit count.
  - In all other cases, increment the tick counter.
- After DATA_BIT samples, the first received bit is at o_data[0].
- Clocks with i_tick=0 change nothing.
- S_DONE:
  - o_done_tick=1 for this one clk.
  - If i_continuous, go to S_RECV and clear both counters and the shift register.
  - Otherwise go to S_IDLE.
- i_stop in S_RECV:
  - Next state is S_IDLE.
  - No o_done_tick; o_data keeps its old value.
  - i_stop has priority over i_tick in the same clk.
- i_stop in S_DONE is ignored; the pulse still fires.
- i_start outside S_IDLE is ignored.
- Illegal state encoding → S_IDLE on the next clk.

## Timing

- Reset values:
  - o_data=0, o_done_tick=0, o_busy=0, state S_IDLE, counters 0.
  - Asserting rst mid-frame discards the partial word immediately.
- o_done_tick is decoded from state S_DONE. o_data is registered and already holds the new word in the clk where o_done_tick=1.
- Latency, with i_tick high every clk:
  - i_start sampled at edge E0 puts the block in S_RECV after E0.
  - The first counted tick is the clk after E0.
  - S_DONE is entered at edge E0 + DATA_BIT·TICK_PER_BIT, and o_done_tick is high during the following clk.
- Sample point: tick index TICK_PER_BIT/2 within each bit, i.e. mid-bit.
- Continuous mode: S_DONE costs exactly one clk before the next frame's tick 0. This matches the serializer's one-clk done state, so back-to-back frames stay aligned.

## Configuration

- SERIAL_IN_MAJORITY_EN defined:
  - Sample i_serial at tick indices H-1, H and H+1, where H = TICK_PER_BIT/2.
  - The bit shifted in is the 2-of-3 majority.
  - Elaboration fails ($error) if TICK_PER_BIT < 4.
- Not defined:
  - Single sample at index H.
  - No vote registers are instantiated.

## Test plan

- Basic frame, single sample:
  - Stimulus: DATA_BIT=16, TICK_PER_BIT=16, i_tick every clk, i_start pulse, then i_serial driven LSB first with 16'hA5C3, 16 clks per bit.
  - Response: o_data=16'hA5C3, and o_done_tick high exactly once, in the clk after edge E0+256.
- Slow tick:
  - Stimulus: i_tick every 4th clk, word 16'h0001.
  - Response: o_data=16'h0001; o_busy stays high for 4·256 clks ±4.
- Abort:
  - Stimulus: i_stop after 5 bits of 16'hFFFF, with o_data previously 16'h1234.
  - Response: no o_done_tick, o_data stays 16'h1234, o_busy=0 on the next clk.
- Continuous mode:
  - Stimulus: i_continuous=1; words 16'h00FF then 16'hFF00 sent back to back, with a one-clk gap matching the serializer.
  - Response: two o_done_tick pulses 257 clks apart, carrying o_data values 16'h00FF then 16'hFF00.
- Glitch rejection, SERIAL_IN_MAJORITY_EN defined:
  - Stimulus: word 16'h0000 with a one-clk high glitch at tick 8 of every bit.
  - Response: o_data=16'h0000. Without the macro, the same stimulus gives 16'hFFFF.
- Reset mid-frame:
  - Stimulus: rst high for 1 clk during bit 7.
  - Response: all outputs 0 immediately. A subsequent i_start with 16'h5A5A receives correctly.
